// File: rtl/secuenciador_vectores.sv
// secuenciador_vectores
// Exhaustive stimulus/response checker for a two-input, two-output
// combinational module under test. It walks (a,b) through 00, 01, 10, 11,
// holds each vector for HOLD cycles, and samples {o1,o2} on the edge that
// closes each hold window. Each sample is compared against the EXPECTED
// truth table, and the run ends with an error count, a per-vector fail
// bitmap and a pass flag.
//
// Parameters
//   HOLD      cycles each vector is held (1..65535)
//   EXPECTED  bits [2v+1:2v] = {o1,o2} expected for vector v
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   start      begins a run; only honoured in IDLE or DONE
//   a, b       stimulus bits (a = v[1], b = v[0]); registered
//   o1, o2     outputs of the module under test
//   busy       high while vectors are being applied
//   done       high once all four vectors are checked
//   pass       1 iff done and no vector mismatched
//   err_count  number of mismatching vectors (0..4)
//   fail_vec   bit v set if vector v mismatched
module secuenciador_vectores #(
    parameter int          HOLD     = 20,
    parameter logic [7:0]  EXPECTED = 8'b10010100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       o1,
    input  logic       o2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD - 1);

    logic [1:0]  state_r;
    logic [1:0]  v_r;
    logic [15:0] h_r;
    logic [2:0]  err_r;
    logic [3:0]  fail_r;
    logic        a_r;
    logic        b_r;
    logic        busy_r;
    logic        done_r;
    logic        pass_r;

    logic        window_end_s;
    logic        mismatch_s;
    logic [1:0]  v_inc_s;
    logic [2:0]  err_next_s;
    logic [3:0]  fail_next_s;

    // Expected {o1,o2} pair for a given vector.
    function automatic logic [1:0] expected_pair(input logic [1:0] vec);
        logic [1:0] pair;
        case (vec)
            2'd0:    pair = EXPECTED[1:0];
            2'd1:    pair = EXPECTED[3:2];
            2'd2:    pair = EXPECTED[5:4];
            2'd3:    pair = EXPECTED[7:6];
            default: pair = 2'b00;
        endcase
        return pair;
    endfunction

    // Window-end detection and the result update that applies on that edge.
    always_comb begin
        window_end_s = (h_r == HOLD_LAST);
        mismatch_s   = ({o1, o2} != expected_pair(v_r));
        v_inc_s      = v_r + 2'd1;
        if (mismatch_s) begin
            err_next_s  = err_r + 3'd1;
            fail_next_s = fail_r | (4'b0001 << v_r);
        end else begin
            err_next_s  = err_r;
            fail_next_s = fail_r;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            v_r     <= 2'd0;
            h_r     <= 16'd0;
            err_r   <= 3'd0;
            fail_r  <= 4'd0;
            a_r     <= 1'b0;
            b_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // Results stay frozen here until the next start.
                    if (start) begin
                        state_r <= ST_APPLY;
                        v_r     <= 2'd0;
                        h_r     <= 16'd0;
                        err_r   <= 3'd0;
                        fail_r  <= 4'd0;
                        a_r     <= 1'b0;
                        b_r     <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    // start is deliberately not looked at in this state.
                    if (window_end_s) begin
                        err_r  <= err_next_s;
                        fail_r <= fail_next_s;
                        h_r    <= 16'd0;
                        if (v_r == 2'd3) begin
                            state_r <= ST_DONE;
                            a_r     <= 1'b0;
                            b_r     <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (err_next_s == 3'd0);
                        end else begin
                            v_r <= v_inc_s;
                            a_r <= v_inc_s[1];
                            b_r <= v_inc_s[0];
                        end
                    end else begin
                        h_r <= h_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    a_r     <= 1'b0;
                    b_r     <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign a         = a_r;
    assign b         = b_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_r;
    assign fail_vec  = fail_r;

endmodule

// File: doc/secuenciador_vectores.md
# secuenciador_vectores

Synthesizable stimulus and response stage for two-input/two-output combinational modules under test. Drives the four exhaustive input vectors (a,b) = 00, 01, 10, 11 into the downstream module, holding each for a programmable number of cycles. Samples the module's two outputs at the end of each hold window and compares them against a parameterized truth table. Reports error count, per-vector fail bitmap and a pass flag, so the check runs on hardware without a simulator.

## Interface
- HOLD, 20, cycles each vector is held on a/b (legal range 1..65535)
- EXPECTED, 8'b10010100, expected outputs; bits [2v+1:2v] = {o1,o2} for vector v (default encodes o1=a&b, o2=a^b)

- clk  in  1  rising-edge clock, single clock domain
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk
- start  in  1  begin a run; sampled in IDLE or DONE only
- a  out  1  stimulus bit, = v[1] of current vector
- b  out  1  stimulus bit, = v[0] of current vector
- o1  in  1  first output of module under test
- o2  in  1  second output of module under test
- busy  out  1  high while vectors are being applied
- done  out  1  high once all four vectors are checked, until restart/reset
- pass  out  1  valid when done; 1 iff err_count == 0
- err_count  out  3  number of mismatching vectors (0..4)
- fail_vec  out  4  bit v set if vector v mismatched

## Operation
- FSM states: IDLE, APPLY, DONE. Registers: vector index v (2 bits), hold counter h (16 bits), err_count, fail_vec.
- IDLE: a=b=0, busy=0, done=0. start=1 -> APPLY, v=0, h=0, err_count=0, fail_vec=0.
- APPLY: busy=1, a=v[1], b=v[0] (registered outputs). h increments each cycle.
- On the edge where h==HOLD-1:
  - Compare {o1,o2} with EXPECTED[2v+1:2v].
  - On mismatch: err_count+=1, fail_vec[v]=1.
  - If v<3: v+=1, h=0. If v==3: go to DONE.
- DONE: a=b=0, busy=0, done=1, pass=(err_count==0). Results hold stable.
  - start=1 in DONE restarts exactly as from IDLE and clears results on the same edge.
- start while in APPLY is ignored; no effect on v, h or results.
- o1/o2 are assumed combinational from a/b. They are sampled only at the end of each hold window, never mid-window.
- err_count cannot overflow: maximum value 4 fits in 3 bits.

## Timing
- Reset (reset_n low at a rising edge) forces state=IDLE regardless of current state, including mid-APPLY.
  - Outputs after reset: a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
  - A partial run is discarded; no results are retained.
- reset_n low and start high on the same edge: reset wins.
- start sampled high at edge k:
  - busy=1 and a/b=vector 0 from edge k to edge k+4*HOLD.
  - done=1 and results valid after edge k+4*HOLD.
- Vector v is driven during cycles [k+v*HOLD, k+(v+1)*HOLD). It is sampled at edge k+(v+1)*HOLD.
- HOLD=1: each vector is held one cycle and sampled at the next edge; done 4 cycles after start.
- pass is 0 whenever done=0.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with start=1 and random o1/o2 -> all outputs 0, state IDLE.
- Correct module (o1=a&b, o2=a^b), HOLD=20:
  - Stimulus: start pulse at edge k.
  - Required: a,b = 00,01,10,11 for 20 cycles each; done=1 at k+80; pass=1, err_count=0, fail_vec=0000.
- Faulty module (o2 stuck at 0), HOLD=20:
  - Stimulus: start pulse.
  - Required: mismatches on vectors 1 and 2; err_count=2, fail_vec=0110, pass=0.
- Start handling:
  - start pulses at k+5 and k+50 during a run -> ignored; done still at k+80.
  - start in DONE -> results cleared next edge; new run completes 80 cycles later.
- Reset mid-run: reset_n=0 at k+30 -> next edge IDLE with all outputs 0. A subsequent start runs a full sequence: done after 80 cycles, pass=1.
- HOLD=1 with the correct module: a,b step one vector per cycle; done=1 four edges after start; pass=1.
